// File: rtl/issue_scoreboard2.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scoreboard2
//  Purpose  : Dual-issue interlock and scoreboard at the F/D -> D/X boundary
//             of the 2-wide pipeline. Decides which of the two decoded
//             instructions may advance into D/X this cycle. It stalls only
//             the hazards that the X/M and M/W bypass paths cannot cover:
//             load-use distance 1, intra-pair RAW, structural pair
//             conflicts and outstanding multdiv results.
//  Config   : SB_MULTDIV_EN  - when defined, multdiv results are tracked
//             with a pending flag and destination register, and the
//             multdiv pair rules are active. When undefined, fd_multDiv_x
//             and md_done are ignored and multdiv is treated as an ALU
//             writer.
//  Ports    : clock, reset_n          - clock, async active-low reset
//             fd_valid_x              - F/D slot x holds an instruction
//             fd_rs_x/rt_x/rd_x       - register specifiers of slot x
//             fd_srcMask_x            - {reads rd, reads rt, reads rs}
//             fd_regWrite_x           - slot x writes fd_rd_x
//             fd_memToReg_x           - slot x is a load
//             fd_memOp_x              - slot x is a load or store
//             fd_multDiv_x            - slot x is mult/div
//             md_done                 - multdiv writes its result now
//             flush                   - kill the F/D contents
//             issue_1, issue_2        - slot advances into D/X now
//             hold_fd                 - F/D latch and PC must not advance
//             slot2_only              - slot 1 of this pair already issued
//  Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard2 (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       fd_valid_1,
   input  logic       fd_valid_2,
   input  logic [4:0] fd_rs_1,
   input  logic [4:0] fd_rt_1,
   input  logic [4:0] fd_rd_1,
   input  logic [4:0] fd_rs_2,
   input  logic [4:0] fd_rt_2,
   input  logic [4:0] fd_rd_2,
   input  logic [2:0] fd_srcMask_1,
   input  logic [2:0] fd_srcMask_2,
   input  logic       fd_regWrite_1,
   input  logic       fd_regWrite_2,
   input  logic       fd_memToReg_1,
   input  logic       fd_memToReg_2,
   input  logic       fd_memOp_1,
   input  logic       fd_memOp_2,
   input  logic       fd_multDiv_1,
   input  logic       fd_multDiv_2,
   input  logic       md_done,
   input  logic       flush,
   output logic       issue_1,
   output logic       issue_2,
   output logic       hold_fd,
   output logic       slot2_only
);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_HALF   = 1'b1
   } state_t;

   state_t state_q, state_d;

   // Cycles remaining until each register is forwardable to D/X. Entry 0
   // is never written and always reads zero.
   logic [31:0][1:0] ready_cnt_q, ready_cnt_d;

   // Per-register "not yet forwardable" vector, combining counters and the
   // outstanding multdiv destination.
   logic [31:0] w_busy;

   logic w_blk_1, w_blk_2;
   logic w_waw_1, w_waw_2;
   logic w_split;
   logic w_split_md;
   logic w_issue_1, w_issue_2, w_hold;

   // -------------------------------------------------------------------------
   // Multdiv tracking
   // -------------------------------------------------------------------------
`ifdef SB_MULTDIV_EN
   logic       md_pend_q, md_pend_d;
   logic [4:0] md_rd_q, md_rd_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         md_pend_q <= 1'b0;
         md_rd_q   <= 5'd0;
      end else begin
         md_pend_q <= md_pend_d;
         md_rd_q   <= md_rd_d;
      end
   end

   // Completion clears first so that a same-cycle new issue overrides it;
   // slot 2 is applied last but the pair rules never issue two multdivs.
   always_comb begin
      md_pend_d = md_pend_q;
      md_rd_d   = md_rd_q;
      if (md_done) begin
         md_pend_d = 1'b0;
      end
      if (w_issue_1 && fd_multDiv_1) begin
         md_pend_d = 1'b1;
         md_rd_d   = fd_rd_1;
      end
      if (w_issue_2 && fd_multDiv_2) begin
         md_pend_d = 1'b1;
         md_rd_d   = fd_rd_2;
      end
   end

   // A writer targeting the outstanding multdiv destination would be
   // overwritten out of order by the late multdiv result.
   assign w_waw_1 = md_pend_q && fd_regWrite_1 && (fd_rd_1 != 5'd0) && (fd_rd_1 == md_rd_q);
   assign w_waw_2 = md_pend_q && fd_regWrite_2 && (fd_rd_2 != 5'd0) && (fd_rd_2 == md_rd_q);

   // Only one multdiv per pair, and slot 2's multdiv must not issue beside
   // a slot-1 writer (its result path shares the write-back port).
   assign w_split_md = (fd_multDiv_1 && fd_multDiv_2) || (fd_regWrite_1 && fd_multDiv_2);

   always_comb begin
      w_busy = '0;
      for (int r = 1; r < 32; r++) begin
         w_busy[r] = (ready_cnt_q[r] != 2'd0) || (md_pend_q && (md_rd_q == 5'(r)));
      end
   end
`else
   assign w_waw_1    = 1'b0;
   assign w_waw_2    = 1'b0;
   assign w_split_md = 1'b0;

   // Multdiv inputs have no effect in this build.
   logic unused_md;
   assign unused_md = fd_multDiv_1 ^ fd_multDiv_2 ^ md_done;

   always_comb begin
      w_busy = '0;
      for (int r = 1; r < 32; r++) begin
         w_busy[r] = (ready_cnt_q[r] != 2'd0);
      end
   end
`endif

   // -------------------------------------------------------------------------
   // Slot hazards. w_busy[0] is always 0, so r0 sources never block.
   // -------------------------------------------------------------------------
   assign w_blk_1 = fd_valid_1 &&
                    ((fd_srcMask_1[0] && w_busy[fd_rs_1]) ||
                     (fd_srcMask_1[1] && w_busy[fd_rt_1]) ||
                     (fd_srcMask_1[2] && w_busy[fd_rd_1]) ||
                     w_waw_1);

   assign w_blk_2 = fd_valid_2 &&
                    ((fd_srcMask_2[0] && w_busy[fd_rs_2]) ||
                     (fd_srcMask_2[1] && w_busy[fd_rt_2]) ||
                     (fd_srcMask_2[2] && w_busy[fd_rd_2]) ||
                     w_waw_2);

   // -------------------------------------------------------------------------
   // Pair rules: conditions under which slot 2 cannot travel with slot 1.
   // -------------------------------------------------------------------------
   logic w_raw_pair;
   assign w_raw_pair = fd_regWrite_1 && (fd_rd_1 != 5'd0) &&
                       ((fd_srcMask_2[0] && (fd_rs_2 == fd_rd_1)) ||
                        (fd_srcMask_2[1] && (fd_rt_2 == fd_rd_1)) ||
                        (fd_srcMask_2[2] && (fd_rd_2 == fd_rd_1)));

   assign w_split = fd_valid_1 && fd_valid_2 &&
                    (w_raw_pair || (fd_memOp_1 && fd_memOp_2) || w_split_md);

   // -------------------------------------------------------------------------
   // Issue FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      w_issue_1 = 1'b0;
      w_issue_2 = 1'b0;
      w_hold    = 1'b0;
      state_d   = state_q;
      if (flush) begin
         // The F/D contents are dead; let the fetch redirect go through.
         state_d = ST_NORMAL;
      end else begin
         case (state_q)
            ST_NORMAL: begin
               if (!fd_valid_1) begin
                  // Slot 2 is evaluated on its own; no split is possible.
                  w_issue_2 = fd_valid_2 && !w_blk_2;
                  w_hold    = w_blk_2;
               end else if (w_blk_1) begin
                  w_hold = 1'b1;
               end else if (fd_valid_2 && (w_blk_2 || w_split)) begin
                  w_issue_1 = 1'b1;
                  w_hold    = 1'b1;
                  state_d   = ST_HALF;
               end else begin
                  w_issue_1 = 1'b1;
                  w_issue_2 = fd_valid_2;
               end
            end
            ST_HALF: begin
               // Slot 1 already left; only slot 2 remains in F/D.
               if (!w_blk_2) begin
                  w_issue_2 = fd_valid_2;
                  state_d   = ST_NORMAL;
               end else begin
                  w_hold = 1'b1;
               end
            end
            default: begin
               state_d = ST_NORMAL;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Scoreboard counters. Decrement first, then issue writes override, with
   // slot 2 last so its latency wins on a shared destination.
   // -------------------------------------------------------------------------
   always_comb begin
      ready_cnt_d = '0;
      for (int r = 1; r < 32; r++) begin
         ready_cnt_d[r] = (ready_cnt_q[r] != 2'd0) ? (ready_cnt_q[r] - 2'd1) : 2'd0;
      end
      if (w_issue_1 && fd_regWrite_1 && (fd_rd_1 != 5'd0)) begin
         ready_cnt_d[fd_rd_1] = fd_memToReg_1 ? 2'd1 : 2'd0;
      end
      if (w_issue_2 && fd_regWrite_2 && (fd_rd_2 != 5'd0)) begin
         ready_cnt_d[fd_rd_2] = fd_memToReg_2 ? 2'd1 : 2'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_cnt_q <= '0;
      end else begin
         ready_cnt_q <= ready_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs are forced low for the whole time reset is asserted.
   // -------------------------------------------------------------------------
   assign issue_1    = reset_n && w_issue_1;
   assign issue_2    = reset_n && w_issue_2;
   assign hold_fd    = reset_n && w_hold;
   assign slot2_only = reset_n && (state_q == ST_HALF);

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scoreboard2
//  Purpose  : Directed self-checking bench for issue_scoreboard2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard2;

   logic       clk;
   logic       reset_n;
   logic       fd_valid_1, fd_valid_2;
   logic [4:0] fd_rs_1, fd_rt_1, fd_rd_1;
   logic [4:0] fd_rs_2, fd_rt_2, fd_rd_2;
   logic [2:0] fd_srcMask_1, fd_srcMask_2;
   logic       fd_regWrite_1, fd_regWrite_2;
   logic       fd_memToReg_1, fd_memToReg_2;
   logic       fd_memOp_1, fd_memOp_2;
   logic       fd_multDiv_1, fd_multDiv_2;
   logic       md_done;
   logic       flush;
   logic       issue_1, issue_2, hold_fd, slot2_only;

   int n_total;
   int n_bad;

   issue_scoreboard2 u_dut (
      .clock         (clk),
      .reset_n       (reset_n),
      .fd_valid_1    (fd_valid_1),
      .fd_valid_2    (fd_valid_2),
      .fd_rs_1       (fd_rs_1),
      .fd_rt_1       (fd_rt_1),
      .fd_rd_1       (fd_rd_1),
      .fd_rs_2       (fd_rs_2),
      .fd_rt_2       (fd_rt_2),
      .fd_rd_2       (fd_rd_2),
      .fd_srcMask_1  (fd_srcMask_1),
      .fd_srcMask_2  (fd_srcMask_2),
      .fd_regWrite_1 (fd_regWrite_1),
      .fd_regWrite_2 (fd_regWrite_2),
      .fd_memToReg_1 (fd_memToReg_1),
      .fd_memToReg_2 (fd_memToReg_2),
      .fd_memOp_1    (fd_memOp_1),
      .fd_memOp_2    (fd_memOp_2),
      .fd_multDiv_1  (fd_multDiv_1),
      .fd_multDiv_2  (fd_multDiv_2),
      .md_done       (md_done),
      .flush         (flush),
      .issue_1       (issue_1),
      .issue_2       (issue_2),
      .hold_fd       (hold_fd),
      .slot2_only    (slot2_only)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic got, input logic exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Checks all four outputs against expected values.
   task automatic chk_out(input string tag, input logic e_i1, input logic e_i2,
                          input logic e_hold, input logic e_s2o);
      chk({tag, ".issue_1"},    issue_1,    e_i1);
      chk({tag, ".issue_2"},    issue_2,    e_i2);
      chk({tag, ".hold_fd"},    hold_fd,    e_hold);
      chk({tag, ".slot2_only"}, slot2_only, e_s2o);
   endtask

   // Slot setup: v, rs, rt, rd, mask, regWrite, memToReg, memOp, multDiv
   task automatic s1(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [2:0] m, input logic rw,
                     input logic mtr, input logic mem, input logic md);
      fd_valid_1 = v; fd_rs_1 = rs; fd_rt_1 = rt; fd_rd_1 = rd; fd_srcMask_1 = m;
      fd_regWrite_1 = rw; fd_memToReg_1 = mtr; fd_memOp_1 = mem; fd_multDiv_1 = md;
   endtask

   task automatic s2(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [2:0] m, input logic rw,
                     input logic mtr, input logic mem, input logic md);
      fd_valid_2 = v; fd_rs_2 = rs; fd_rt_2 = rt; fd_rd_2 = rd; fd_srcMask_2 = m;
      fd_regWrite_2 = rw; fd_memToReg_2 = mtr; fd_memOp_2 = mem; fd_multDiv_2 = md;
   endtask

   task automatic idle;
      s1(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      s2(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs change just after the rising edge; outputs are sampled on the
   // falling edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      md_done = 1'b0;
      flush   = 1'b0;
      idle();

      // Reset: a clear ALU op in slot 1 must still not issue.
      s1(1'b1, 5'd1, 5'd2, 5'd3, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      idle();
      tick();

      // Load-use: lw r5 ; add r6,r5,r2
      s1(1'b1, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      settle(); chk_out("lu_c1", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      s1(1'b1, 5'd5, 5'd2, 5'd6, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("lu_c2", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      settle(); chk_out("lu_c3", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();

      // Intra-pair RAW: add r3,r1,r2 ; sub r4,r3,r1
      s1(1'b1, 5'd1, 5'd2, 5'd3, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd3, 5'd1, 5'd4, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("raw_n", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      settle(); chk_out("raw_n1", 1'b0, 1'b1, 1'b0, 1'b1);
      tick();

      // Structural: lw r7 ; sw r8 (store reads rs and rd)
      s1(1'b1, 5'd1, 5'd0, 5'd7, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      s2(1'b1, 5'd2, 5'd0, 5'd8, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0);
      settle(); chk_out("mem_n", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      settle(); chk_out("mem_n1", 1'b0, 1'b1, 1'b0, 1'b1);
      tick();

      // Flush during HALF: lw r5 ; add r10,r5,r1 splits, then blocks in HALF
      s1(1'b1, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      s2(1'b1, 5'd5, 5'd1, 5'd10, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("fl_split", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      flush = 1'b1;
      settle(); chk_out("fl_half", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      idle();
      settle(); chk_out("fl_after", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Same rd in both slots: slot 2 (ALU) latency wins over slot 1 (load)
      s1(1'b1, 5'd1, 5'd0, 5'd12, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      s2(1'b1, 5'd1, 5'd2, 5'd12, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("waw_a", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      s1(1'b1, 5'd12, 5'd0, 5'd13, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("waw_a_rd", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      // Reverse: slot 2 load wins
      s1(1'b1, 5'd1, 5'd2, 5'd14, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd1, 5'd0, 5'd14, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      settle(); chk_out("waw_b", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      s1(1'b1, 5'd14, 5'd0, 5'd15, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("waw_b_rd", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      tick();

      // Invalid slot 1 reading a busy register never blocks slot 2
      s1(1'b1, 5'd1, 5'd0, 5'd16, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      s1(1'b0, 5'd16, 5'd16, 5'd16, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd1, 5'd0, 5'd17, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("inv1_clr", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      // Invalid slot 1, blocked slot 2 evaluated alone
      s1(1'b1, 5'd1, 5'd0, 5'd18, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      fd_valid_2 = 1'b0;
      tick();
      s1(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd18, 5'd0, 5'd19, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("inv1_blk", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      settle(); chk_out("inv1_go", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();

`ifdef SB_MULTDIV_EN
      // mul r9 ; jr r9 holds until md_done, issuing the cycle after
      s1(1'b1, 5'd1, 5'd2, 5'd9, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
      settle(); chk_out("md_issue", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      s1(1'b1, 5'd0, 5'd0, 5'd9, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("md_hold1", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      flush = 1'b1;
      settle(); chk_out("md_flush", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      flush = 1'b0;
      settle(); chk_out("md_hold2", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      md_done = 1'b1;
      settle(); chk_out("md_done", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      md_done = 1'b0;
      settle(); chk_out("md_go", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      // Slot 1 writer with slot 2 multdiv splits
      s1(1'b1, 5'd1, 5'd0, 5'd20, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd1, 5'd0, 5'd21, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
      settle(); chk_out("md_pair", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      settle(); chk_out("md_pair2", 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      idle();
      md_done = 1'b1;
      tick();
      md_done = 1'b0;
`else
      // Multdiv behaves as an ALU writer: no pending tracking
      md_done = 1'b0;
      s1(1'b1, 5'd1, 5'd2, 5'd9, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
      settle(); chk_out("md_issue", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      s1(1'b1, 5'd0, 5'd0, 5'd9, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("md_nohold", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      s1(1'b1, 5'd1, 5'd0, 5'd20, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      s2(1'b1, 5'd1, 5'd0, 5'd21, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
      settle(); chk_out("md_pair", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
`endif
      idle();
      tick();

      // Reset mid-HALF with ready_cnt[5] = 1
      s1(1'b1, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
      s2(1'b1, 5'd5, 5'd1, 5'd10, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      settle(); chk_out("rst_split", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      reset_n = 1'b0;
      settle(); chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      idle();
      s1(1'b1, 5'd5, 5'd2, 5'd6, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      chk_out("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/issue_scoreboard2.md
# issue_scoreboard2

Dual-issue interlock and scoreboard for the 2-wide pipeline. It sits at the F/D→D/X boundary and decides which of the two decoded instructions may advance into D/X each cycle. It stalls exactly those hazards that the downstream bypass network cannot cover:

- load-use distance 1;
- intra-pair RAW;
- structural pair conflicts;
- outstanding multdiv results.

Every hazard it lets through must be forwardable from X/M or M/W of either pipe.

## Interface
- No parameters. Register file is fixed at 32 × 5-bit specifiers; r0 is never tracked.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `fd_valid_1`, `fd_valid_2`  in  1  — F/D slot holds a real instruction.
- `fd_rs_x`, `fd_rt_x`, `fd_rd_x`  in  5 each (x = 1, 2)  — source and destination specifiers.
- `fd_srcMask_x`  in  3  — bit0 reads rs, bit1 reads rt, bit2 reads rd (branches, jr, stores).
- `fd_regWrite_x`  in  1  — slot writes `fd_rd_x`.
- `fd_memToReg_x`  in  1  — slot is a load.
- `fd_memOp_x`  in  1  — slot is a load or a store.
- `fd_multDiv_x`  in  1  — slot is mult/div.
- `md_done`  in  1  — multdiv unit is writing its result this cycle.
- `flush`  in  1  — taken branch/jump; kill the F/D contents.
- `issue_1`, `issue_2`  out  1  — the slot advances into D/X this cycle.
- `hold_fd`  out  1  — F/D latch and PC must not advance.
- `slot2_only`  out  1  — FSM is in HALF; slot 1 was already issued.

## Operation
**Scoreboard state**
- `ready_cnt[r]` (2 bits) for r = 1..31: number of cycles before a value is forwardable to D/X.
- Issue of a writer sets `ready_cnt[rd]`:
  - load → 1;
  - ALU or other writer → 0.
- All nonzero counters decrement by 1 every cycle, saturating at 0.
- `md_pend` (1 bit) and `md_rd` (5 bits): set when a multdiv issues; cleared when `md_done` is high.

**Slot hazard.** A source s of a slot (per its mask, s ≠ 0) is blocked if either:
- `ready_cnt[s]` ≠ 0, or
- `md_pend` is set and s == `md_rd`.

A writer slot whose rd == `md_rd` while `md_pend` is set is also blocked (WAW).

**Pair rules.** Slot 2 is split off (slot 1 issues alone) if any of the following holds:
- slot 2 reads slot 1's rd, with slot 1 writing and rd ≠ 0;
- both slots are memory ops;
- both slots are multdiv;
- slot 1 writes and `fd_multDiv_2` is set.

**FSM (2 states)**
- **NORMAL**
  - Slot 1 blocked → `issue_1` = `issue_2` = 0, `hold_fd` = 1.
  - Slot 1 clear and slot 2 clear, with no split → both issue, `hold_fd` = 0.
  - Slot 1 clear, but slot 2 blocked or split → `issue_1` = 1, `issue_2` = 0, `hold_fd` = 1, next state HALF.
  - Slot 1 invalid → treated as clear with nothing issued; slot 2 is evaluated alone.
- **HALF**
  - Slot 1 is ignored.
  - Slot 2 clear → `issue_2` = 1, `hold_fd` = 0, next state NORMAL.
  - Otherwise → hold and remain in HALF.
- An invalid slot never issues and never blocks.

**Simultaneous and boundary events**
- Same rd written by both slots of one issued pair: slot 2's latency wins.
- Issue setting `ready_cnt[r]` in the same cycle that r decrements: the new value wins.
- `md_done` and a new multdiv issue in the same cycle: the set wins, and `md_rd` takes the new rd.
- `flush`:
  - outputs `issue_1` = `issue_2` = 0 and `hold_fd` = 0;
  - FSM goes to NORMAL;
  - scoreboard is untouched, because D/X and older instructions complete.

## Timing
- `issue_x`, `hold_fd` and `slot2_only` are combinational from the F/D inputs and registered state within the same cycle. Scoreboard and FSM update at the next edge.
- Load issued at cycle t (in D/X at t+1):
  - a dependent instruction in F/D at t+1 is held;
  - it issues at t+2, entering D/X at t+3 with the load in M/W.
- ALU producer: a dependent instruction in the next cycle is never held.
- Reset, applied asynchronously at any time including mid-HALF or with a multdiv pending:
  - all `ready_cnt` = 0, `md_pend` = 0, `md_rd` = 0, FSM = NORMAL;
  - while `reset_n` = 0: `issue_1` = `issue_2` = 0, `hold_fd` = 0, `slot2_only` = 0.

## Configuration
- `SB_MULTDIV_EN` defined:
  - `md_pend`/`md_rd` tracking and the multdiv pair rules are built in.
- `SB_MULTDIV_EN` not defined:
  - `fd_multDiv_x` and `md_done` are ignored;
  - multdiv is scoreboarded as an ALU writer (latency 0);
  - `md_pend` logic is absent.

## Test plan
- Load-use: slot 1 = `lw r5`, issued at cycle 1; next pair slot 1 = `add r6,r5,r2` → `hold_fd` = 1 at cycle 2, `issue_1` = 1 at cycle 3.
- Intra-pair RAW: slot 1 = `add r3,r1,r2`, slot 2 = `sub r4,r3,r1`, scoreboard clear:
  - cycle n: `issue_1` = 1, `slot2_only` next cycle;
  - cycle n+1: `issue_2` = 1, `hold_fd` = 0.
- Structural: slot 1 `lw r7`, slot 2 `sw r8` → split with the same two-cycle pattern; no scoreboard hazard is reported.
- Multdiv (macro on):
  - `mul r9` issues;
  - `jr r9` (mask bit2) holds until the cycle `md_done` = 1;
  - it issues the following cycle.
- Flush during HALF → next cycle FSM is NORMAL and `issue_2` = 0; a prior `lw r5` still blocks r5 for its remaining cycle.
- Reset asserted mid-HALF with `ready_cnt[5]` = 1 → all outputs 0 immediately; after release, a reader of r5 issues on the first cycle.
